// File: rtl/agc_pkg.sv
// ============================================================================
// Module   : agc_pkg
// Purpose  : Shared AGC sample formats and the round/saturate helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package agc_pkg;

    localparam int W_IN     = 26;
    localparam int FRAC_IN  = 18;
    localparam int W_OUT    = 16;
    localparam int FRAC_OUT = 14;
    localparam int SHIFT    = FRAC_IN - FRAC_OUT;

    localparam logic signed [W_IN:0] SAT_MAX = (W_IN+1)'((1 << (W_OUT-1)) - 1);
    localparam logic signed [W_IN:0] SAT_MIN = (W_IN+1)'(-(1 << (W_OUT-1)));
    localparam logic signed [W_IN:0] RND_OFS = (W_IN+1)'(1 << (SHIFT-1));

    typedef struct packed {
        logic             sat;
        logic [W_OUT-1:0] data;
    } rs_t;

    // Round half up, computed one bit wider than the input so +offset cannot overflow.
    function automatic rs_t round_sat(input logic [W_IN-1:0] x);
        logic signed [W_IN:0] w_sum;
        logic signed [W_IN:0] w_r;
        rs_t                  res;
        w_sum    = $signed({x[W_IN-1], x}) + RND_OFS;
        w_r      = w_sum >>> SHIFT;
        res.sat  = 1'b0;
        res.data = w_r[W_OUT-1:0];
        if (w_r > SAT_MAX) begin
            res.sat  = 1'b1;
            res.data = SAT_MAX[W_OUT-1:0];
        end else if (w_r < SAT_MIN) begin
            res.sat  = 1'b1;
            res.data = SAT_MIN[W_OUT-1:0];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/agc_stream_egress_if.sv
// ============================================================================
// Module   : agc_stream_egress_if
// Purpose  : AGC sample input, downstream valid/ready channel and statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface agc_stream_egress_if
    import agc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
);
    logic                  s_agc_valid;
    logic [W_IN-1:0]       s_agc_dataI;
    logic [W_IN-1:0]       s_agc_dataQ;
    logic [W_OUT-1:0]      m_chans_dataI;
    logic [W_OUT-1:0]      m_chans_dataQ;
    logic                  m_chans_valid;
    logic                  m_chans_ready;
    logic                  clr_stats;
    logic [CNT_W-1:0]      sat_count;
    logic [CNT_W-1:0]      drop_count;
    logic                  overflow;
    logic [DEPTH_LOG2:0]   fifo_level;

    // Egress block side
    modport master (
        input  s_agc_valid, s_agc_dataI, s_agc_dataQ, m_chans_ready, clr_stats,
        output m_chans_dataI, m_chans_dataQ, m_chans_valid,
               sat_count, drop_count, overflow, fifo_level
    );

    // Producer/consumer side
    modport slave (
        output s_agc_valid, s_agc_dataI, s_agc_dataQ, m_chans_ready, clr_stats,
        input  m_chans_dataI, m_chans_dataQ, m_chans_valid,
               sat_count, drop_count, overflow, fifo_level
    );
endinterface

`default_nettype wire

// File: rtl/agc_sync_fifo.sv
// ============================================================================
// Module   : agc_sync_fifo
// Purpose  : Synchronous FIFO with wrap-bit pointers; head read from storage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module agc_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_push,
    input  wire logic [WIDTH-1:0]      i_wdata,
    input  wire logic                  i_pop,
    output logic      [WIDTH-1:0]      o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic      [DEPTH_LOG2:0]   o_level
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_do_pop;
    logic                w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                       (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rdata   = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wdata;
                r_wr_ptr                        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/agc_stream_egress.sv
// ============================================================================
// Module   : agc_stream_egress
// Purpose  : Rounds/saturates AGC output to (16,14), buffers it, keeps stats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module agc_stream_egress
    import agc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    agc_stream_egress_if.master  bus
);
    logic             r_st1_valid;
    logic             r_st1_sat;
    logic [W_OUT-1:0] r_st1_i;
    logic [W_OUT-1:0] r_st1_q;
    logic [CNT_W-1:0] r_sat_count;
    logic [CNT_W-1:0] r_drop_count;
    logic             r_overflow;

    rs_t                   w_rs_i;
    rs_t                   w_rs_q;
    logic [2*W_OUT-1:0]    w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_level;

    assign w_rs_i = round_sat(bus.s_agc_dataI);
    assign w_rs_q = round_sat(bus.s_agc_dataQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st1_valid <= 1'b0;
            r_st1_sat   <= 1'b0;
            r_st1_i     <= '0;
            r_st1_q     <= '0;
        end else begin
            r_st1_valid <= bus.s_agc_valid;
            r_st1_sat   <= w_rs_i.sat | w_rs_q.sat;
            r_st1_i     <= w_rs_i.data;
            r_st1_q     <= w_rs_q.data;
        end
    end

    assign w_pop  = ~w_empty & bus.m_chans_ready;
    assign w_drop = r_st1_valid & w_full & ~w_pop;

    agc_sync_fifo #(
        .WIDTH      (2*W_OUT),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_st1_valid),
        .i_wdata ({r_st1_i, r_st1_q}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Clear wins over any increment landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (bus.clr_stats) begin
            r_sat_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_st1_valid && r_st1_sat && (r_sat_count != '1)) begin
                r_sat_count <= r_sat_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    assign bus.m_chans_dataI = w_head[2*W_OUT-1:W_OUT];
    assign bus.m_chans_dataQ = w_head[W_OUT-1:0];
    assign bus.m_chans_valid = ~w_empty;
    assign bus.fifo_level    = w_level;
    assign bus.sat_count     = r_sat_count;
    assign bus.drop_count    = r_drop_count;
    assign bus.overflow      = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_agc_stream_egress.sv
// ============================================================================
// Module   : tb_agc_stream_egress
// Purpose  : Scoreboard bench for agc_stream_egress.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_agc_stream_egress;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] q_exp [$];

    agc_stream_egress_if #(.DEPTH_LOG2(3), .CNT_W(16)) bus ();

    agc_stream_egress #(.DEPTH_LOG2(3), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [25:0] x);
        longint v;
        v = longint'($signed(x));
        v = (v + 8) >>> 4;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [25:0] mk(input int k);
        logic [31:0] t;
        t = k * 16;
        return t[25:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [25:0] i, input logic [25:0] q, input bit expect_push);
        bus.s_agc_valid = 1'b1;
        bus.s_agc_dataI = i;
        bus.s_agc_dataQ = q;
        if (expect_push) q_exp.push_back({model(i), model(q)});
        tick();
        bus.s_agc_valid = 1'b0;
    endtask

    task automatic clear_stats;
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
    endtask

    task automatic wait_drain;
        for (int n = 0; n < 60 && q_exp.size() != 0; n++) tick();
        check_eq("drain", q_exp.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.m_chans_valid && bus.m_chans_ready) begin
            if (q_exp.size() == 0) begin
                check_eq("unexpected_out", q_exp.size(), 1);
            end else begin
                check_eq("out_IQ", {bus.m_chans_dataI, bus.m_chans_dataQ}, q_exp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ri, rq;
        bus.s_agc_valid   = 1'b0;
        bus.s_agc_dataI   = '0;
        bus.s_agc_dataQ   = '0;
        bus.m_chans_ready = 1'b0;
        bus.clr_stats     = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_valid", bus.m_chans_valid, 0);
        check_eq("rst_level", bus.fifo_level, 0);
        check_eq("rst_data", {bus.m_chans_dataI, bus.m_chans_dataQ}, 0);
        check_eq("rst_sat", bus.sat_count, 0);
        check_eq("rst_drop", bus.drop_count, 0);
        check_eq("rst_ovf", bus.overflow, 0);
        rst = 1'b0;
        tick();

        // Rounding and 2-cycle latency
        bus.m_chans_ready = 1'b1;
        strobe(26'h0000008, 26'h3FFFFF7, 1'b1);
        check_eq("lat1_valid", bus.m_chans_valid, 0);
        tick();
        check_eq("lat2_valid", bus.m_chans_valid, 1);
        check_eq("round_I", bus.m_chans_dataI, 16'h0001);
        check_eq("round_Q", bus.m_chans_dataQ, 16'hFFFF);
        tick();
        check_eq("round_sat_cnt", bus.sat_count, 0);

        // Saturation
        strobe(26'h1FFFFFF, 26'h2000000, 1'b1);
        strobe(mk(32767), 26'h0, 1'b1);
        check_eq("sat_I", bus.m_chans_dataI, 16'h7FFF);
        check_eq("sat_Q", bus.m_chans_dataQ, 16'h8000);
        wait_drain();
        check_eq("sat_cnt", bus.sat_count, 1);

        // Random back-to-back traffic
        for (int k = 0; k < 20; k++) begin
            ri = $urandom;
            rq = $urandom;
            if (k % 4 == 0) ri[25:22] = 4'b0000;
            strobe(ri[25:0], rq[25:0], 1'b1);
        end
        wait_drain();

        // Backpressure: 10 strobes into 8 slots
        clear_stats();
        check_eq("clr_sat", bus.sat_count, 0);
        bus.m_chans_ready = 1'b0;
        for (int k = 1; k <= 10; k++) strobe(mk(k), mk(-k), k <= 8);
        tick();
        check_eq("bp_level", bus.fifo_level, 8);
        check_eq("bp_drop", bus.drop_count, 2);
        check_eq("bp_ovf", bus.overflow, 1);
        repeat (2) tick();
        check_eq("bp_hold_I", bus.m_chans_dataI, 16'h0001);
        check_eq("bp_hold_Q", bus.m_chans_dataQ, 16'hFFFF);
        bus.m_chans_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_eq("b2b_valid", bus.m_chans_valid, 1);
            tick();
        end
        check_eq("b2b_level", bus.fifo_level, 0);
        check_eq("b2b_queue", q_exp.size(), 0);

        // Full with simultaneous push and pop
        clear_stats();
        bus.m_chans_ready = 1'b0;
        for (int k = 20; k <= 27; k++) strobe(mk(k), mk(k), 1'b1);
        strobe(mk(28), mk(-28), 1'b1);
        check_eq("fp_pre_level", bus.fifo_level, 8);
        bus.m_chans_ready = 1'b1;
        tick();
        bus.m_chans_ready = 1'b0;
        check_eq("fp_level", bus.fifo_level, 8);
        check_eq("fp_drop", bus.drop_count, 0);
        check_eq("fp_ovf", bus.overflow, 0);
        bus.m_chans_ready = 1'b1;
        wait_drain();

        // Clear coinciding with a drop
        bus.m_chans_ready = 1'b0;
        for (int k = 30; k <= 37; k++) strobe(mk(k), mk(-k), 1'b1);
        strobe(mk(38), mk(38), 1'b0);
        clear_stats();
        check_eq("clr_drop", bus.drop_count, 0);
        check_eq("clr_ovf", bus.overflow, 0);
        check_eq("clr_level", bus.fifo_level, 8);
        bus.m_chans_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with buffered samples
        bus.m_chans_ready = 1'b0;
        for (int k = 40; k <= 44; k++) strobe(mk(k), mk(k), 1'b0);
        repeat (2) tick();
        check_eq("ar_pre_level", bus.fifo_level, 5);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", bus.m_chans_valid, 0);
        check_eq("ar_level", bus.fifo_level, 0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        bus.m_chans_ready = 1'b1;
        strobe(mk(50), mk(-50), 1'b1);
        check_eq("ar_lat1_valid", bus.m_chans_valid, 0);
        tick();
        check_eq("ar_lat2_valid", bus.m_chans_valid, 1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/agc_stream_egress.md
Name: agc_stream_egress

Overview:
- Reader/consumer side of the AGC core's output interface (Valid_Out, OutputI, OutputQ; 26-bit, 18 fractional bits).
- Rounds each sample to 16-bit (16,14) I/Q with saturation.
- Buffers samples in a small FIFO and presents them downstream on a valid/ready channel (m_chans_*), mirroring the s_chans_* input convention.
- Keeps saturation and drop statistics for AGC tuning.

Parameters:
- W_IN, 26, input sample width (two's complement)
- FRAC_IN, 18, input fractional bits
- W_OUT, 16, output sample width
- FRAC_OUT, 14, output fractional bits; SHIFT = FRAC_IN-FRAC_OUT, must be ≥1
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_agc_valid  in  1  AGC output sample valid (single-cycle strobe, no backpressure)
- s_agc_dataI  in  W_IN  AGC I output
- s_agc_dataQ  in  W_IN  AGC Q output
- m_chans_dataI  out  W_OUT  rounded/saturated I
- m_chans_dataQ  out  W_OUT  rounded/saturated Q
- m_chans_valid  out  1  FIFO head valid
- m_chans_ready  in  1  downstream accept
- clr_stats  in  1  synchronous clear of counters and sticky flag
- sat_count  out  CNT_W  samples with I or Q saturated (saturating counter)
- drop_count  out  CNT_W  samples lost to FIFO full (saturating counter)
- overflow  out  1  sticky: set on any drop
- fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, FIFO empty, pointers 0, stage-1 valid 0. Reset mid-stream discards all buffered samples.
- Stage 1, registered, 1 cycle:
  - For each of I and Q: r = (x + 2**(SHIFT-1)) >>> SHIFT, arithmetic, computed at W_IN+1 bits (round half up).
  - If r > 2**(W_OUT-1)-1, clamp to max; if r < -2**(W_OUT-1), clamp to min.
  - sat flag = I clamped OR Q clamped. Stage-1 valid follows s_agc_valid.
- Stage 2, FIFO write:
  - push = st1_valid. pop = m_chans_valid & m_chans_ready.
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped: drop_count +1 and overflow set.
  - Full with a simultaneous pop: the push succeeds and the level is unchanged.
  - Empty with push: no bypass. The sample is written and becomes visible the next cycle.
  - Latency from s_agc_valid to m_chans_valid on an empty FIFO with ready high: 2 cycles.
- Output: m_chans_data* is the FIFO head (registered). m_chans_valid = level≠0.
  - Head data must stay stable while valid & !ready.
  - Back-to-back pops at 1 sample/clk are supported.
- Pointers: DEPTH_LOG2+1 bits with a wrap bit. full = MSBs differ and LSBs equal. Pointers wrap modulo 2**(DEPTH_LOG2+1).
- fifo_level = wr_ptr - rd_ptr, updated the same cycle as push/pop.
- sat_count: +1 per stage-1 sample with the sat flag, including samples later dropped.
- Counters saturate at 2**CNT_W-1 and do not wrap.
- clr_stats has priority over increments in the same cycle: counters become 0 and overflow becomes 0. It does not affect the FIFO.
- A sample arriving on the same cycle as clr_stats is not counted.

Decomposition:
- Shared package agc_pkg: W_IN/FRAC_IN/W_OUT/FRAC_OUT defaults, SHIFT constant, sat_max/sat_min constants. The AGC core and this block both import it.
- One sub-module: agc_sync_fifo, a parameterised width/depth synchronous FIFO with push/pop/full/empty/level. Instantiate it once with width 2*W_OUT.
- Rounding/saturation stays inline as a function in agc_pkg (round_sat).

Test Plan:
- Rounding: I=0x0000_0008 (0.5 LSB out), Q=0x3FF_FFF7 (-9) -> m_chans_dataI=1, dataQ=-1 (0xFFFF), 2 cycles after strobe, sat_count stays 0.
- Saturation: I=+2**25-1, Q=-2**25 -> dataI=0x7FFF, dataQ=0x8000, sat_count=1. I=+32767*16 -> 0x7FFF with no sat increment.
- Backpressure/full: ready=0, 10 strobes on consecutive cycles -> fifo_level=8, drop_count=2, overflow=1. Releasing ready yields samples 1..8 in order, one per clk.
- Full+pop simultaneous: FIFO full, ready=1 and a strobe on the same cycle -> no drop, level stays 8, the new sample appears last.
- clr_stats same cycle as a drop -> drop_count=0, overflow=0 next cycle, FIFO contents intact.
- Async reset with 5 buffered samples, asserted between clock edges -> m_chans_valid=0 and fifo_level=0 immediately. The first strobe after release gives valid 2 cycles later.
